rf_wb_arbiter: RTL and testbench

//  Writeback arbiter directly upstream of the 1-write/2-read register file.

---
 rtl/rf_wb_arbiter_if.sv | 31 +++
 rtl/rf_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: ALU result, load return handshake, hazard mask and RF write port.
interface rf_wb_arbiter_if;
  logic        i_alu_vld;
  logic [3:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        o_alu_stall;
  logic        i_ld_vld;
  logic        o_ld_rdy;
  logic [3:0]  i_ld_rd;
  logic [1:0]  i_ld_size;
  logic        i_ld_sext;
  logic [1:0]  i_ld_boff;
  logic [31:0] i_ld_data;
  logic [15:0] o_pend_mask;
  logic [3:0]  o_waddr;
  logic [3:0]  o_wen;
  logic        o_cs_b;
  logic [31:0] o_din;

  modport master (
    output i_alu_vld, i_alu_rd, i_alu_data, i_ld_vld, i_ld_rd, i_ld_size,
           i_ld_sext, i_ld_boff, i_ld_data,
    input  o_alu_stall, o_ld_rdy, o_pend_mask, o_waddr, o_wen, o_cs_b, o_din
  );

  modport slave (
    input  i_alu_vld, i_alu_rd, i_alu_data, i_ld_vld, i_ld_rd, i_ld_size,
           i_ld_sext, i_ld_boff, i_ld_data,
    output o_alu_stall, o_ld_rdy, o_pend_mask, o_waddr, o_wen, o_cs_b, o_din
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Merges ALU results and queued/aligned load returns onto the single RF write port,
// with ALU-starvation protection and a pending-load register mask.
module rf_wb_arbiter #(
  parameter int unsigned LD_DEPTH   = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clk_en,
  rf_wb_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(LD_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic        live;
    logic [3:0]  rd;
    logic [31:0] data;
  } ld_ent_t;

  ld_ent_t            ent_q [LD_DEPTH];
  ld_ent_t            ent_d [LD_DEPTH];
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_mid;
  logic [STV_W-1:0]   stv_q, stv_d;
  logic               ld_rdy_q, ld_rdy_d;
  logic               cs_b_q, cs_b_d;
  logic [3:0]         wen_q, wen_d;
  logic [3:0]         waddr_q, waddr_d;
  logic [31:0]        din_q, din_d;

  logic               alu_stall_c, alu_go, ld_acc, empty, pop, byp, push;
  logic [4:0]         shamt;
  logic [31:0]        shifted, ld_aligned;
  logic [15:0]        pend_mask_c;

  // Load data alignment and extension, done once at acceptance.
  always_comb begin
    shamt = 5'd0;
    case (bus.i_ld_size)
      2'b00:   shamt = {bus.i_ld_boff, 3'b000};
      2'b01:   shamt = {bus.i_ld_boff[1], 4'b0000};
      default: shamt = 5'd0;
    endcase
    shifted = bus.i_ld_data >> shamt;
    case (bus.i_ld_size)
      2'b00:   ld_aligned = {{24{bus.i_ld_sext & shifted[7]}}, shifted[7:0]};
      2'b01:   ld_aligned = {{16{bus.i_ld_sext & shifted[15]}}, shifted[15:0]};
      default: ld_aligned = shifted;
    endcase
  end

  always_comb begin
    alu_stall_c = (stv_q >= STV_W'(STARVE_MAX));
    alu_go      = !alu_stall_c && bus.i_alu_vld;
    ld_acc      = bus.i_ld_vld && ld_rdy_q && i_clk_en && !i_rst &&
                  (cnt_q < CNT_W'(LD_DEPTH));
    empty       = (cnt_q == '0);
    pop         = i_clk_en && !empty && !alu_go;
    byp         = empty && ld_acc && !alu_go;
    push        = ld_acc && !byp;
    cnt_mid     = pop ? cnt_q - CNT_W'(1) : cnt_q;

    pend_mask_c = '0;
    for (int i = 0; i < int'(LD_DEPTH); i++)
      if (ent_q[i].live) pend_mask_c = pend_mask_c | (16'(1) << ent_q[i].rd);
    if (byp) pend_mask_c = pend_mask_c | (16'(1) << bus.i_ld_rd);
  end

  always_comb begin
    ent_d   = ent_q;
    cnt_d   = cnt_q;
    stv_d   = stv_q;
    cs_b_d  = cs_b_q;
    wen_d   = wen_q;
    waddr_d = waddr_q;
    din_d   = din_q;

    if (i_clk_en) begin
      cs_b_d = 1'b1;
      wen_d  = 4'h0;
      if (alu_go) begin
        cs_b_d  = 1'b0;
        wen_d   = 4'hF;
        waddr_d = bus.i_alu_rd;
        din_d   = bus.i_alu_data;
        // Older queued loads to the same register are superseded by this write.
        for (int i = 0; i < int'(LD_DEPTH); i++)
          if (ent_d[i].live && ent_d[i].rd == bus.i_alu_rd) ent_d[i].live = 1'b0;
      end else if (pop) begin
        if (ent_q[0].live) begin
          cs_b_d  = 1'b0;
          wen_d   = 4'hF;
          waddr_d = ent_q[0].rd;
          din_d   = ent_q[0].data;
        end
      end else if (byp) begin
        cs_b_d  = 1'b0;
        wen_d   = 4'hF;
        waddr_d = bus.i_ld_rd;
        din_d   = ld_aligned;
      end

      if (pop) begin
        for (int i = 0; i < int'(LD_DEPTH) - 1; i++) ent_d[i] = ent_d[i + 1];
        ent_d[LD_DEPTH-1].live = 1'b0;
      end
      for (int i = 0; i < int'(LD_DEPTH); i++)
        if (push && CNT_W'(i) == cnt_mid)
          ent_d[i] = '{live: 1'b1, rd: bus.i_ld_rd, data: ld_aligned};
      cnt_d = push ? cnt_mid + CNT_W'(1) : cnt_mid;

      if (pop)         stv_d = '0;
      else if (!empty) stv_d = stv_q + STV_W'(1);
    end
    ld_rdy_d = (cnt_d < CNT_W'(LD_DEPTH));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(LD_DEPTH); i++) ent_q[i] <= '0;
      cnt_q    <= '0;
      stv_q    <= '0;
      ld_rdy_q <= 1'b0;
      cs_b_q   <= 1'b1;
      wen_q    <= 4'h0;
      waddr_q  <= 4'h0;
      din_q    <= 32'h0;
    end else begin
      ent_q    <= ent_d;
      cnt_q    <= cnt_d;
      stv_q    <= stv_d;
      ld_rdy_q <= ld_rdy_d;
      cs_b_q   <= cs_b_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      din_q    <= din_d;
    end
  end

  assign bus.o_alu_stall = alu_stall_c;
  assign bus.o_ld_rdy    = ld_rdy_q;
  assign bus.o_pend_mask = pend_mask_c;
  assign bus.o_waddr     = waddr_q;
  assign bus.o_wen       = wen_q;
  assign bus.o_cs_b      = cs_b_q;
  assign bus.o_din       = din_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
  logic i_clk = 1'b0;
  logic i_rst;
  logic i_clk_en;
  int   errors = 0;
  int   checks = 0;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.LD_DEPTH(2), .STARVE_MAX(4)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clk_en (i_clk_en),
    .bus      (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input string tag, input logic [3:0] a, input logic [31:0] d);
    chk({tag, ".cs_b"}, 32'(bus.o_cs_b), 32'd0);
    chk({tag, ".wen"}, 32'(bus.o_wen), 32'hF);
    chk({tag, ".waddr"}, 32'(bus.o_waddr), 32'(a));
    chk({tag, ".din"}, bus.o_din, d);
  endtask

  task automatic idle(input string tag);
    chk({tag, ".cs_b"}, 32'(bus.o_cs_b), 32'd1);
    chk({tag, ".wen"}, 32'(bus.o_wen), 32'd0);
  endtask

  task automatic alu(input logic v, input logic [3:0] rd, input logic [31:0] d);
    bus.i_alu_vld = v; bus.i_alu_rd = rd; bus.i_alu_data = d;
  endtask

  task automatic ld(input logic v, input logic [3:0] rd, input logic [1:0] sz,
                    input logic sx, input logic [1:0] bo, input logic [31:0] d);
    bus.i_ld_vld = v; bus.i_ld_rd = rd; bus.i_ld_size = sz;
    bus.i_ld_sext = sx; bus.i_ld_boff = bo; bus.i_ld_data = d;
  endtask

  initial begin
    i_rst = 1'b1; i_clk_en = 1'b1;
    alu(1'b0, 4'd0, 32'h0);
    ld(1'b0, 4'd0, 2'b10, 1'b0, 2'd0, 32'h0);
    tick(); tick();
    idle("rst");
    chk("rst.waddr", 32'(bus.o_waddr), 32'd0);
    chk("rst.din", bus.o_din, 32'h0);
    chk("rst.ld_rdy", 32'(bus.o_ld_rdy), 32'd0);
    chk("rst.mask", 32'(bus.o_pend_mask), 32'h0);
    chk("rst.stall", 32'(bus.o_alu_stall), 32'd0);
    i_rst = 1'b0;
    tick();
    chk("post_rst.ld_rdy", 32'(bus.o_ld_rdy), 32'd1);

    // ALU write, one-cycle latency
    alu(1'b1, 4'd3, 32'h12345678);
    tick(); alu(1'b0, 4'd0, 32'h0);
    wr("alu", 4'd3, 32'h12345678);
    tick();
    idle("alu_idle");
    chk("alu_idle.waddr_hold", 32'(bus.o_waddr), 32'd3);

    // Bypassed byte load with sign extension
    ld(1'b1, 4'd7, 2'b00, 1'b1, 2'd2, 32'h0080_0000);
    #1 chk("byp.mask", 32'(bus.o_pend_mask), 32'h0080);
    tick(); ld(1'b0, 4'd0, 2'b10, 1'b0, 2'd0, 32'h0);
    wr("byte", 4'd7, 32'hFFFF_FF80);
    // Half load, zero extended, boff[0] ignored
    ld(1'b1, 4'd8, 2'b01, 1'b0, 2'd3, 32'h8001_0000);
    tick(); ld(1'b0, 4'd0, 2'b10, 1'b0, 2'd0, 32'h0);
    wr("half", 4'd8, 32'h0000_8001);

    // ALU and load in the same cycle: ALU first, load next
    alu(1'b1, 4'd1, 32'hAAAA_0001);
    ld(1'b1, 4'd2, 2'b10, 1'b1, 2'd1, 32'hCAFE_F00D);
    tick(); alu(1'b0, 4'd0, 32'h0); ld(1'b0, 4'd0, 2'b10, 1'b0, 2'd0, 32'h0);
    wr("same.alu", 4'd1, 32'hAAAA_0001);
    chk("same.mask1", 32'(bus.o_pend_mask), 32'h0004);
    tick();
    wr("same.ld", 4'd2, 32'hCAFE_F00D);
    chk("same.mask2", 32'(bus.o_pend_mask), 32'h0000);

    // Starvation: continuous ALU, loads back to back
    alu(1'b1, 4'd9, 32'h99);
    ld(1'b1, 4'd10, 2'b10, 1'b0, 2'd0, 32'h10);
    tick();
    chk("stv.rdy1", 32'(bus.o_ld_rdy), 32'd1);
    ld(1'b1, 4'd11, 2'b10, 1'b0, 2'd0, 32'h11);
    tick();
    chk("stv.rdy_full", 32'(bus.o_ld_rdy), 32'd0);
    chk("stv.mask", 32'(bus.o_pend_mask), 32'h0C00);
    chk("stv.stall0", 32'(bus.o_alu_stall), 32'd0);
    ld(1'b1, 4'd12, 2'b10, 1'b0, 2'd0, 32'h12);
    tick(); tick();
    chk("stv.stall3", 32'(bus.o_alu_stall), 32'd0);
    tick();
    chk("stv.stall4", 32'(bus.o_alu_stall), 32'd1);
    wr("stv.alu", 4'd9, 32'h99);
    tick();
    wr("stv.pop", 4'd10, 32'h10);
    chk("stv.stall_drop", 32'(bus.o_alu_stall), 32'd0);
    chk("stv.rdy_back", 32'(bus.o_ld_rdy), 32'd1);
    chk("stv.mask2", 32'(bus.o_pend_mask), 32'h0800);
    alu(1'b0, 4'd0, 32'h0); ld(1'b0, 4'd0, 2'b10, 1'b0, 2'd0, 32'h0);
    tick();
    wr("stv.pop2", 4'd11, 32'h11);
    chk("stv.mask3", 32'(bus.o_pend_mask), 32'h0000);

    // Kill: queued load to R5 overwritten by younger ALU write
    alu(1'b1, 4'd4, 32'h44);
    ld(1'b1, 4'd5, 2'b10, 1'b0, 2'd0, 32'h5555_5555);
    tick(); ld(1'b0, 4'd0, 2'b10, 1'b0, 2'd0, 32'h0);
    wr("kill.alu4", 4'd4, 32'h44);
    chk("kill.mask1", 32'(bus.o_pend_mask), 32'h0020);
    alu(1'b1, 4'd5, 32'hA5A5_A5A5);
    tick(); alu(1'b0, 4'd0, 32'h0);
    wr("kill.alu5", 4'd5, 32'hA5A5_A5A5);
    chk("kill.mask2", 32'(bus.o_pend_mask), 32'h0000);
    tick();
    idle("kill.dead_pop");
    chk("kill.waddr_hold", 32'(bus.o_waddr), 32'd5);

    // Same-cycle ALU and load to the same rd: load survives
    alu(1'b1, 4'd6, 32'h66);
    ld(1'b1, 4'd6, 2'b10, 1'b0, 2'd0, 32'h77);
    tick(); alu(1'b0, 4'd0, 32'h0); ld(1'b0, 4'd0, 2'b10, 1'b0, 2'd0, 32'h0);
    wr("young.alu", 4'd6, 32'h66);
    chk("young.mask", 32'(bus.o_pend_mask), 32'h0040);
    tick();
    wr("young.ld", 4'd6, 32'h77);

    // Reset with full FIFO
    alu(1'b1, 4'd1, 32'h1);
    ld(1'b1, 4'd13, 2'b10, 1'b0, 2'd0, 32'hD);
    tick();
    ld(1'b1, 4'd14, 2'b10, 1'b0, 2'd0, 32'hE);
    tick();
    chk("mrst.full", 32'(bus.o_ld_rdy), 32'd0);
    i_rst = 1'b1;
    alu(1'b0, 4'd0, 32'h0); ld(1'b0, 4'd0, 2'b10, 1'b0, 2'd0, 32'h0);
    tick();
    idle("mrst");
    chk("mrst.mask", 32'(bus.o_pend_mask), 32'h0);
    chk("mrst.rdy", 32'(bus.o_ld_rdy), 32'd0);
    i_rst = 1'b0;
    tick();
    chk("mrst.rdy_after", 32'(bus.o_ld_rdy), 32'd1);
    idle("mrst.after1");
    tick();
    idle("mrst.after2");

    // Clock enable freeze with two queued loads
    alu(1'b1, 4'd2, 32'h22);
    ld(1'b1, 4'd3, 2'b10, 1'b0, 2'd0, 32'h33);
    tick();
    ld(1'b1, 4'd4, 2'b10, 1'b0, 2'd0, 32'h44);
    tick();
    i_clk_en = 1'b0;
    alu(1'b1, 4'd9, 32'hDEAD);
    ld(1'b1, 4'd15, 2'b10, 1'b0, 2'd0, 32'hBEEF);
    for (int i = 0; i < 3; i++) begin
      tick();
      wr("ce.frozen", 4'd2, 32'h22);
      chk("ce.mask", 32'(bus.o_pend_mask), 32'h0018);
    end
    alu(1'b0, 4'd0, 32'h0); ld(1'b0, 4'd0, 2'b10, 1'b0, 2'd0, 32'h0);
    i_clk_en = 1'b1;
    tick();
    wr("ce.pop1", 4'd3, 32'h33);
    tick();
    wr("ce.pop2", 4'd4, 32'h44);
    chk("ce.mask_end", 32'(bus.o_pend_mask), 32'h0);
    tick();
    idle("ce.empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
